// File: rtl/door_motion_supervisor_if.sv
// Door supervisor signal bundle: buttons and sensors in, motor drives and status out.
// master drives buttons/sensors (plant side); slave is the supervisor.
interface door_motion_supervisor_if;
  logic Btn_Wall;
  logic Btn_Remote;
  logic UP_Max;
  logic DN_Max;
  logic Obstacle;
  logic UP_M;
  logic DN_M;
  logic Fault;
  logic Door_Open;

  modport master (
    output Btn_Wall,
    output Btn_Remote,
    output UP_Max,
    output DN_Max,
    output Obstacle,
    input  UP_M,
    input  DN_M,
    input  Fault,
    input  Door_Open
  );

  modport slave (
    input  Btn_Wall,
    input  Btn_Remote,
    input  UP_Max,
    input  DN_Max,
    input  Obstacle,
    output UP_M,
    output DN_M,
    output Fault,
    output Door_Open
  );
endinterface

// File: rtl/door_motion_supervisor.sv
// Garage-door motion supervisor: Moore FSM with travel timeout, auto-close and reversal.
// Ports: CLK, RST (async active-low), io (buttons/limits/obstacle in, motors/status out).
module door_motion_supervisor #(
  parameter int TRAVEL_MAX = 1000,
  parameter int AUTO_CLOSE = 5000,
  parameter int DEAD_TIME  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  door_motion_supervisor_if.slave  io
);

  typedef enum logic [2:0] {
    CLOSED,
    OPENING,
    OPEN,
    CLOSING,
    STOPPED,
    REV_WAIT,
    FAULT
  } state_t;

  localparam logic [15:0] TRAVEL_LAST = 16'(TRAVEL_MAX - 1);
  localparam logic [15:0] CLOSE_LAST  = 16'(AUTO_CLOSE - 1);
  localparam logic [15:0] DEAD_LAST   = 16'(DEAD_TIME - 1);

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic        last_dir;
  logic        btn_prev;
  logic        btn;
  logic        cmd;
  logic        both_lim;

  assign btn      = io.Btn_Wall | io.Btn_Remote;
  assign cmd      = btn & ~btn_prev;
  assign both_lim = io.UP_Max & io.DN_Max;

  always_comb begin
    state_n = state;
    unique case (state)
      CLOSED: begin
        if (cmd)
          state_n = OPENING;
        else if (!io.DN_Max)
          state_n = STOPPED;
      end
      OPENING: begin
        if (both_lim)
          state_n = FAULT;
        else if (io.UP_Max)
          state_n = OPEN;
        else if (cmd)
          state_n = STOPPED;
        else if (cnt == TRAVEL_LAST)
          state_n = FAULT;
      end
      CLOSING: begin
        if (both_lim)
          state_n = FAULT;
        else if (io.DN_Max)
          state_n = CLOSED;
        else if (io.Obstacle)
          state_n = REV_WAIT;
        else if (cmd)
          state_n = STOPPED;
        else if (cnt == TRAVEL_LAST)
          state_n = FAULT;
      end
      OPEN: begin
        if (cmd)
          state_n = CLOSING;
        else if (!io.Obstacle && cnt == CLOSE_LAST)
          state_n = CLOSING;
      end
      REV_WAIT: begin
        if (cnt == DEAD_LAST)
          state_n = OPENING;
      end
      STOPPED: begin
        if (both_lim)
          state_n = FAULT;
        else if (io.DN_Max)
          state_n = CLOSED;
        else if (io.UP_Max)
          state_n = OPEN;
        else if (cmd)
          state_n = last_dir ? CLOSING : OPENING;
      end
      FAULT: state_n = FAULT;
      default: state_n = FAULT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= STOPPED;
      cnt      <= '0;
      last_dir <= 1'b1;
      btn_prev <= 1'b0;
    end else begin
      btn_prev <= btn;
      state    <= state_n;
      if (state_n != state)
        cnt <= '0;
      else if (state == OPEN && io.Obstacle)
        cnt <= '0;
      else if (cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
      if (state_n != state && state_n == OPENING)
        last_dir <= 1'b1;
      else if (state_n != state && state_n == CLOSING)
        last_dir <= 1'b0;
    end
  end

  // Outputs decode from the state register only; reset state STOPPED
  // decodes to all-zero, so reset clears them without a clock.
  assign io.UP_M      = (state == OPENING);
  assign io.DN_M      = (state == CLOSING);
  assign io.Fault     = (state == FAULT);
  assign io.Door_Open = (state == OPEN);

endmodule

// File: tb/tb_door_motion_supervisor.sv
// Scoreboard bench for door_motion_supervisor with short timing parameters.
// Expected {UP_M,DN_M,Fault,Door_Open} per edge is queued and checked by a monitor.
module tb_door_motion_supervisor;

  logic CLK;
  logic RST;

  door_motion_supervisor_if io ();

  door_motion_supervisor #(
    .TRAVEL_MAX(20),
    .AUTO_CLOSE(30),
    .DEAD_TIME (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .io (io.slave)
  );

  localparam logic [3:0] OFF = 4'b0000;
  localparam logic [3:0] UP  = 4'b1000;
  localparam logic [3:0] DN  = 4'b0100;
  localparam logic [3:0] FLT = 4'b0010;
  localparam logic [3:0] OPN = 4'b0001;

  typedef struct {
    logic [3:0] e;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [3:0] outs();
    return {io.UP_M, io.DN_M, io.Fault, io.Door_Open};
  endfunction

  initial begin : monitor
    exp_t x;
    logic [3:0] got;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        x   = q.pop_front();
        got = outs();
        checks++;
        if (got !== x.e) begin
          failures++;
          $display("FAIL %s got=%b exp=%b t=%0t",
                   x.nm, got, x.e, $time);
        end
      end
    end
  end

  task automatic tick(input logic [3:0] e, input string nm);
    exp_t x;
    x.e  = e;
    x.nm = nm;
    q.push_back(x);
    @(negedge CLK);
  endtask

  task automatic ticks(input int n, input logic [3:0] e,
                       input string nm);
    repeat (n) tick(e, nm);
  endtask

  task automatic chk_now(input logic [3:0] e, input string nm);
    checks++;
    if (outs() !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t",
               nm, outs(), e, $time);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    checks        = 0;
    failures      = 0;
    RST           = 1'b0;
    io.Btn_Wall   = 1'b0;
    io.Btn_Remote = 1'b0;
    io.UP_Max     = 1'b0;
    io.DN_Max     = 1'b1;
    io.Obstacle   = 1'b0;
    repeat (2) @(negedge CLK);
    chk_now(OFF, "reset_outs");
    RST = 1'b1;
    tick(OFF, "resolve_closed");

    io.Btn_Wall = 1'b1;
    tick(UP, "open_cmd");
    io.Btn_Wall = 1'b0;
    io.DN_Max   = 1'b0;
    ticks(4, UP, "opening");
    io.Obstacle = 1'b1;
    tick(UP, "obst_ignored_opening");
    io.Obstacle = 1'b0;
    ticks(4, UP, "opening");
    io.UP_Max = 1'b1;
    tick(OPN, "at_open");
    ticks(29, OPN, "open_wait");
    tick(DN, "auto_close");
    io.UP_Max = 1'b0;
    ticks(2, DN, "closing");

    io.Obstacle = 1'b1;
    tick(OFF, "rev_wait");
    io.Obstacle = 1'b0;
    ticks(3, OFF, "dead_time");
    tick(UP, "reversed");
    io.UP_Max = 1'b1;
    tick(OPN, "reopen");

    io.Obstacle = 1'b1;
    ticks(35, OPN, "obst_hold_open");
    io.Btn_Wall = 1'b1;
    tick(DN, "cmd_close_in_obst");
    io.Btn_Wall = 1'b0;
    tick(OFF, "rev_after_cmd");
    io.Obstacle = 1'b0;
    ticks(3, OFF, "dead_time2");
    tick(UP, "reversed2");
    tick(OPN, "reopen2");
    ticks(29, OPN, "open_wait2");
    tick(DN, "auto_close2");
    io.UP_Max = 1'b0;
    tick(DN, "closing2");

    io.Btn_Remote = 1'b1;
    tick(OFF, "stop_mid_close");
    io.Btn_Remote = 1'b0;
    tick(OFF, "stopped");
    io.Btn_Wall   = 1'b1;
    io.Btn_Remote = 1'b1;
    tick(UP, "resume_up");
    ticks(3, UP, "held_one_cmd");
    io.Btn_Wall   = 1'b0;
    io.Btn_Remote = 1'b0;
    tick(UP, "opening3");
    io.UP_Max = 1'b1;
    io.DN_Max = 1'b1;
    tick(FLT, "limit_conflict");
    io.UP_Max   = 1'b0;
    io.DN_Max   = 1'b0;
    io.Btn_Wall = 1'b1;
    tick(FLT, "fault_hold");
    io.Btn_Wall = 1'b0;
    tick(FLT, "fault_hold");

    RST       = 1'b0;
    io.DN_Max = 1'b1;
    @(negedge CLK);
    chk_now(OFF, "reset_from_fault");
    RST = 1'b1;
    tick(OFF, "resolve_closed2");
    io.Btn_Remote = 1'b1;
    tick(UP, "open_cmd2");
    io.Btn_Remote = 1'b0;
    io.DN_Max     = 1'b0;
    ticks(19, UP, "travel");
    tick(FLT, "travel_timeout");
    io.Btn_Wall = 1'b1;
    tick(FLT, "fault_ignores_cmd");
    io.Btn_Wall = 1'b0;
    tick(FLT, "fault_ignores_cmd");

    RST       = 1'b0;
    io.UP_Max = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    tick(OPN, "resolve_open");
    io.Btn_Wall = 1'b1;
    tick(DN, "close_cmd");
    io.Btn_Wall = 1'b0;
    io.UP_Max   = 1'b0;
    tick(DN, "closing4");
    #2;
    RST = 1'b0;
    #1;
    chk_now(OFF, "async_reset_mid_close");
    @(negedge CLK);

    io.DN_Max = 1'b1;
    RST       = 1'b1;
    tick(OFF, "resolve_closed3");
    io.DN_Max = 1'b0;
    tick(OFF, "closed_lost_limit");
    io.Btn_Wall = 1'b1;
    tick(DN, "lastdir_after_reset");
    io.Btn_Wall = 1'b0;
    ticks(19, DN, "closing5");
    io.DN_Max = 1'b1;
    tick(OFF, "limit_beats_timeout");
    tick(OFF, "closed_final");

    @(posedge CLK);
    #2;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
